// File: rtl/cfg_frame_pkg.sv
// Shared types and helpers for the per-column frame-strobe controller.
package cfg_frame_pkg;

    // Write-sequence phases: wait for command, data setup, strobe pulse, data hold.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int FRAME_IDX_W        = 5;
    localparam int MAX_FRAMES_PER_COL = 20;
    localparam int FRAME_BITS_PER_ROW = 32;
    localparam int COL_SEL_W          = 5;

    // One frame-write command as seen on the handshake.
    typedef struct packed {
        logic [COL_SEL_W-1:0]          col;
        logic [FRAME_IDX_W-1:0]        frame;
        logic [FRAME_BITS_PER_ROW-1:0] data;
    } cmd_t;

    // One-hot strobe pattern for a frame index; out-of-range indices give all zeros.
    function automatic logic [MAX_FRAMES_PER_COL-1:0] onehot_frame(input logic [FRAME_IDX_W-1:0] idx);
        logic [MAX_FRAMES_PER_COL-1:0] vec;
        vec = '0;
        for (int i = 0; i < MAX_FRAMES_PER_COL; i++) begin
            if (idx == FRAME_IDX_W'(i)) vec[i] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/cfg_cycle_counter.sv
// 3-bit loadable down-counter with zero flag; times both the setup and strobe phases.
module cfg_cycle_counter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [2:0] count_q;
    logic [2:0] count_d;

    // Load has priority over decrement; decrement stops at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != 3'd0)) begin
            count_d = count_q - 3'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= 3'd0;
        else       count_q <= count_d;
    end

    assign zero_o = (count_q == 3'd0);

endmodule

// File: rtl/col_frame_strobe_ctrl.sv
// Column configuration write controller: accepts one frame-write command at a time,
// presents the frame data, then pulses a single FrameStrobe bit with setup/hold margins.
module col_frame_strobe_ctrl
    import cfg_frame_pkg::*;
#(
    parameter int MaxFramesPerCol = MAX_FRAMES_PER_COL,
    parameter int FrameBitsPerRow = FRAME_BITS_PER_ROW,
    parameter int ColSelWidth     = COL_SEL_W,
    parameter int ColIndex        = 0,
    parameter int SetupCycles     = 1,
    parameter int StrobeCycles    = 1
) (
    input  logic                       UserCLK,
    input  logic                       Reset,
    input  logic                       Cmd_valid,
    output logic                       Cmd_ready,
    input  logic [ColSelWidth-1:0]     Cmd_col,
    input  logic [4:0]                 Cmd_frame,
    input  logic [FrameBitsPerRow-1:0] Cmd_data,
    output logic [FrameBitsPerRow-1:0] FrameData_o,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_o,
    output logic                       Busy,
    output logic                       Err_o
);

    // Frame limit is compared in the 5-bit index domain (zero-extended/truncated).
    localparam logic [FRAME_IDX_W-1:0] FRAME_LIMIT  = FRAME_IDX_W'(MaxFramesPerCol);
    localparam logic [ColSelWidth-1:0] COL_ID       = ColSelWidth'(ColIndex);
    localparam logic [2:0]             SETUP_LOAD   = 3'(SetupCycles - 1);
    localparam logic [2:0]             STROBE_LOAD  = 3'(StrobeCycles - 1);

    cmd_t                       cmd_in;
    state_t                     state_q, state_d;
    logic                       rdy_en_q;
    logic [FRAME_IDX_W-1:0]     frame_q, frame_d;
    logic [FrameBitsPerRow-1:0] data_q, data_d;
    logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
    logic                       busy_q, busy_d;
    logic                       err_q, err_d;
    logic                       accept, col_hit, frame_ok;
    logic                       cnt_load, cnt_dec, cnt_zero;
    logic [2:0]                 cnt_load_val;

    assign cmd_in   = '{col: Cmd_col, frame: Cmd_frame, data: Cmd_data};
    assign accept   = Cmd_valid && Cmd_ready;
    assign col_hit  = (cmd_in.col == COL_ID);
    assign frame_ok = (cmd_in.frame < FRAME_LIMIT);

    // Ready is a pure state decode, held low until the first clock after reset release.
    assign Cmd_ready = rdy_en_q && (state_q == IDLE);

    cfg_cycle_counter u_counter (
        .clk_i      (UserCLK),
        .rst_i      (Reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // State register plus the post-reset ready enable.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Next-state: only a matching, in-range command starts a sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && col_hit && frame_ok) state_d = SETUP;
            SETUP:   if (cnt_zero) state_d = STROBE;
            STROBE:  if (cnt_zero) state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/counter control: computes next values for the registered outputs.
    always_comb begin
        data_d       = data_q;
        frame_d      = frame_q;
        strobe_d     = strobe_q;
        err_d        = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = SETUP_LOAD;
        cnt_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && col_hit) begin
                    if (frame_ok) begin
                        data_d   = cmd_in.data;
                        frame_d  = cmd_in.frame;
                        cnt_load = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    strobe_d     = onehot_frame(frame_q);
                    cnt_load     = 1'b1;
                    cnt_load_val = STROBE_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            STROBE: begin
                if (cnt_zero) strobe_d = '0;
                else          cnt_dec  = 1'b1;
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Output registers; reset clears strobe and data immediately.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            data_q   <= '0;
            frame_q  <= '0;
            strobe_q <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            data_q   <= data_d;
            frame_q  <= frame_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign FrameData_o   = data_q;
    assign FrameStrobe_o = strobe_q;
    assign Busy          = busy_q;
    assign Err_o         = err_q;

endmodule

// File: tb/tb_col_frame_strobe_ctrl.sv
// Bench for col_frame_strobe_ctrl: two instances with different timing/column settings
// share one command stream; an interval-based reference model predicts every output.
module tb_col_frame_strobe_ctrl;

    localparam int S0 = 1, T0C = 1, COL0 = 0;
    localparam int S1 = 3, T1C = 2, COL1 = 5;
    localparam int NFRAMES = 20;

    logic        UserCLK;
    logic        Reset;
    logic        Cmd_valid;
    logic [4:0]  Cmd_col;
    logic [4:0]  Cmd_frame;
    logic [31:0] Cmd_data;

    logic [1:0]  rdy, busy, err;
    logic [19:0] stb [2];
    logic [31:0] dat [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: each DUT is described by the edge of its last good accept.
    int          e_acc   [2];
    int          frame_m [2];
    logic [31:0] data_m  [2];
    int          err_cyc [2];
    int          rel_cyc;

    col_frame_strobe_ctrl #(.ColIndex(COL0), .SetupCycles(S0), .StrobeCycles(T0C)) u_dut_a (
        .UserCLK(UserCLK), .Reset(Reset), .Cmd_valid(Cmd_valid), .Cmd_ready(rdy[0]),
        .Cmd_col(Cmd_col), .Cmd_frame(Cmd_frame), .Cmd_data(Cmd_data),
        .FrameData_o(dat[0]), .FrameStrobe_o(stb[0]), .Busy(busy[0]), .Err_o(err[0]));

    col_frame_strobe_ctrl #(.ColIndex(COL1), .SetupCycles(S1), .StrobeCycles(T1C)) u_dut_b (
        .UserCLK(UserCLK), .Reset(Reset), .Cmd_valid(Cmd_valid), .Cmd_ready(rdy[1]),
        .Cmd_col(Cmd_col), .Cmd_frame(Cmd_frame), .Cmd_data(Cmd_data),
        .FrameData_o(dat[1]), .FrameStrobe_o(stb[1]), .Busy(busy[1]), .Err_o(err[1]));

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    function automatic int sc(int k);  return (k == 0) ? S0 : S1;     endfunction
    function automatic int tc(int k);  return (k == 0) ? T0C : T1C;   endfunction
    function automatic int colk(int k); return (k == 0) ? COL0 : COL1; endfunction

    // Cycle c = outputs seen after the c-th clock edge; accept at edge E.
    function automatic bit m_ready(int k, int c);
        return (c >= rel_cyc) && (c >= e_acc[k] + sc(k) + tc(k) + 1);
    endfunction
    function automatic bit m_busy(int k, int c);
        return (c >= e_acc[k]) && (c <= e_acc[k] + sc(k) + tc(k));
    endfunction
    function automatic logic [19:0] m_strobe(int k, int c);
        logic [19:0] one;
        one = 20'd1;
        if ((c >= e_acc[k] + sc(k)) && (c < e_acc[k] + sc(k) + tc(k))) return one << frame_m[k];
        return 20'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            e_acc[k]   = -1000;
            frame_m[k] = 0;
            data_m[k]  = 32'd0;
            err_cyc[k] = -1000;
        end
        rel_cyc = 1 << 30;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ready%0d", k),  32'(rdy[k]),  32'(m_ready(k, cyc)));
            chk($sformatf("busy%0d", k),   32'(busy[k]), 32'(m_busy(k, cyc)));
            chk($sformatf("err%0d", k),    32'(err[k]),  32'(cyc == err_cyc[k]));
            chk($sformatf("strobe%0d", k), 32'(stb[k]),  32'(m_strobe(k, cyc)));
            chk($sformatf("data%0d", k),   dat[k],       data_m[k]);
        end
        $display("cyc=%0d v=%0d col=%0d fr=%0d | A rdy=%0d busy=%0d err=%0d stb=%h dat=%h | B rdy=%0d busy=%0d err=%0d stb=%h dat=%h",
                 cyc, Cmd_valid, Cmd_col, Cmd_frame, rdy[0], busy[0], err[0], stb[0], dat[0],
                 rdy[1], busy[1], err[1], stb[1], dat[1]);
    endtask

    // One clock: decide accepts from the model, advance, then check at the falling edge.
    task automatic cycle();
        bit acc [2];
        for (int k = 0; k < 2; k++) acc[k] = Cmd_valid && !Reset && m_ready(k, cyc);
        @(posedge UserCLK);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (acc[k] && (int'(Cmd_col) == colk(k))) begin
                if (int'(Cmd_frame) < NFRAMES) begin
                    e_acc[k]   = cyc;
                    frame_m[k] = int'(Cmd_frame);
                    data_m[k]  = Cmd_data;
                end else begin
                    err_cyc[k] = cyc;
                end
            end
        end
        @(negedge UserCLK);
        check_all();
    endtask

    // Present a command and hold it until instance k (per the model) takes it.
    task automatic send(input logic [4:0] col, input logic [4:0] frame, input logic [31:0] data, input int k);
        bit done;
        Cmd_valid = 1'b1;
        Cmd_col   = col;
        Cmd_frame = frame;
        Cmd_data  = data;
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            done = m_ready(k, cyc);
            cycle();
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL accept_timeout inst=%0d observed=%0d expected=1", k, done);
        end
    endtask

    task automatic idle(input int n);
        Cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        Reset     = 1'b1;
        Cmd_valid = 1'b0;
        Cmd_col   = 5'd0;
        Cmd_frame = 5'd0;
        Cmd_data  = 32'd0;
        model_reset();

        // Reset held: ready low, outputs cleared.
        @(negedge UserCLK);
        check_all();
        idle(2);
        Reset   = 1'b0;
        rel_cyc = cyc + 1;
        idle(2);

        // Basic write on A (B sees a foreign column).
        send(5'd0, 5'd3, 32'hDEADBEEF, 0);
        idle(5);
        // Foreign column for A.
        send(5'd1, 5'd4, 32'h12345678, 0);
        idle(2);
        // Long timing on B, top frame index.
        send(5'd5, 5'd19, 32'hCAFEF00D, 1);
        idle(8);
        // Out-of-range frame on each instance.
        send(5'd0, 5'd20, 32'hBAD0BAD0, 0);
        idle(3);
        send(5'd5, 5'd20, 32'hBAD1BAD1, 1);
        idle(3);
        // Back-to-back on A, valid held throughout.
        send(5'd0, 5'd0, 32'h11111111, 0);
        send(5'd0, 5'd1, 32'h22222222, 0);
        idle(6);

        // Reset asserted while B strobes frame 7.
        send(5'd5, 5'd7, 32'h77777777, 1);
        Cmd_valid = 1'b0;
        for (int n = 0; n < 20 && m_strobe(1, cyc) == 20'd0; n++) cycle();
        #2 Reset = 1'b1;
        #1;
        chk("rst_async_strobe", 32'(stb[1]), 32'd0);
        chk("rst_async_data",   dat[1],      32'd0);
        chk("rst_async_busy",   32'(busy[1]), 32'd0);
        model_reset();
        idle(2);
        Reset   = 1'b0;
        rel_cyc = cyc + 1;
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] cols [4];
            cols[0] = 5'd0; cols[1] = 5'd5; cols[2] = 5'd1; cols[3] = 5'd31;
            Cmd_valid = ($urandom_range(0, 3) != 0);
            Cmd_col   = cols[$urandom_range(0, 3)];
            Cmd_frame = 5'($urandom_range(0, 22));
            Cmd_data  = $urandom;
            cycle();
        end
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/col_frame_strobe_ctrl.md
Name: col_frame_strobe_ctrl

Overview:
- Per-column configuration write controller. It sits directly upstream of a fabric column's tiles (terminal tile included) and drives that column's FrameStrobe bus, plus the per-row frame data.
- It accepts one frame-write command at a time over a valid/ready handshake and checks that the command targets its own column.
- For a matching command it presents the frame data, then pulses exactly one FrameStrobe bit with programmable setup, strobe and hold timing, so config latches capture cleanly.

Parameters:
- MaxFramesPerCol, 20, width of the FrameStrobe bus (frames per column).
- FrameBitsPerRow, 32, frame data width.
- ColSelWidth, 5, width of the column-select field.
- ColIndex, 0, column number this instance answers to.
- SetupCycles, 1, cycles data is stable before the strobe rises (legal range 1..7).
- StrobeCycles, 1, strobe high duration in cycles (legal range 1..7).

Ports:
- UserCLK  in  1  clock.
- Reset  in  1  asynchronous, active-high reset.
- Cmd_valid  in  1  command valid.
- Cmd_ready  out  1  controller can accept a command.
- Cmd_col  in  ColSelWidth  target column.
- Cmd_frame  in  5  target frame index.
- Cmd_data  in  FrameBitsPerRow  frame data.
- FrameData_o  out  FrameBitsPerRow  registered data to the column.
- FrameStrobe_o  out  MaxFramesPerCol  registered one-hot strobe to the column.
- Busy  out  1  a write sequence is in progress.
- Err_o  out  1  one-cycle pulse when a command is rejected for a bad frame index.

Behaviour:
- Reset (async, active-high):
  - Cmd_ready=0 while Reset is high, then 1 from the first clock after release.
  - FrameData_o=0, FrameStrobe_o=0, Busy=0, Err_o=0.
  - FSM=IDLE, counter=0.
- All outputs are registered. No combinational path from Cmd_* to any output except Cmd_ready, which is a state decode.
- Accept occurs on an edge where Cmd_valid && Cmd_ready. Cmd_ready=1 only in IDLE. Cmd_* fields are captured at accept.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE, accept with Cmd_col==ColIndex and Cmd_frame<MaxFramesPerCol: FrameData_o<=Cmd_data, go to SETUP, counter<=SetupCycles-1.
  - IDLE, accept with Cmd_col!=ColIndex: command is consumed silently and the FSM stays in IDLE. No strobe, no error, FrameData_o unchanged.
  - IDLE, accept with matching column and Cmd_frame>=MaxFramesPerCol: consumed, Err_o=1 for the next cycle only, stay in IDLE, no strobe.
  - SETUP: count down. At 0, go to STROBE and set FrameStrobe_o bit Cmd_frame high, counter<=StrobeCycles-1.
  - STROBE: exactly one strobe bit is high. Count down; at 0, clear FrameStrobe_o and go to HOLD.
  - HOLD: one cycle with FrameData_o held and strobe low, then go to IDLE.
- Timing for a matching command accepted at edge T0:
  - Busy=1 from T0+1 through the HOLD cycle.
  - Strobe high on cycles T0+1+SetupCycles .. T0+SetupCycles+StrobeCycles.
  - Cmd_ready returns to 1 at T0+2+SetupCycles+StrobeCycles.
- Back-to-back: a command held valid during a busy sequence waits. It is accepted on the first IDLE cycle; there is no overlap of strobes.
- FrameData_o keeps its last written value in IDLE. It changes only at a matching accept.
- FrameStrobe_o is never multi-hot and never glitches. It is driven from a register and cleared only on a state transition.
- Reset asserted mid-sequence: strobe and data clear immediately (asynchronously). The sequence is abandoned with no resumption after release.
- Widths: the counter is 3 bits. Cmd_frame is compared against MaxFramesPerCol zero-extended to 5 bits.

Decomposition:
- Shared package cfg_frame_pkg contains:
  - the state enum {IDLE, SETUP, STROBE, HOLD};
  - FRAME_IDX_W=5;
  - a cmd struct {col, frame, data};
  - a helper function onehot_frame(idx) returning a MaxFramesPerCol-bit vector.
- One natural sub-module: cfg_cycle_counter, a 3-bit loadable down-counter with a zero flag, shared by the SETUP and STROBE phases.

Test Plan:
- Reset: assert Reset mid-STROBE (frame 7 bit high) -> FrameStrobe_o=0 and FrameData_o=0 immediately, Busy=0; after release, Cmd_ready=1 next cycle.
- Basic write (Setup=1, Strobe=1), col=ColIndex, frame=3, data=32'hDEADBEEF accepted at T0:
  - FrameData_o=DEADBEEF at T0+1;
  - FrameStrobe_o=20'h00008 only at T0+2;
  - Cmd_ready=1 again at T0+4.
- Timing params Setup=3, Strobe=2, frame=19 -> strobe bit 19 high exactly at T0+4 and T0+5, low otherwise; Busy high T0+1..T0+6.
- Wrong column (col=ColIndex+1) -> accepted in one cycle; FrameStrobe_o stays 0, Err_o stays 0, FrameData_o unchanged.
- Bad frame (frame=20 with MaxFramesPerCol=20) -> Err_o=1 for exactly one cycle, no strobe, Cmd_ready stays 1.
- Back-to-back: two valid commands (frames 0 then 1) held continuously -> two non-overlapping single-bit strobes; the second is accepted only after HOLD; FrameData_o switches between them.
